// File: rtl/rng_lfsr_ranged_if.sv
// Output handshake bundle for the ranged LFSR RNG.
// The master presents num/out_valid; the slave answers with out_ready.
interface rng_lfsr_ranged_if #(
    parameter int OUT_W = 4
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] num;

    modport master (
        output out_valid,
        output num,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  num,
        output out_ready
    );
endinterface

// File: rtl/rng_lfsr_ranged.sv
// Fibonacci LFSR RNG with rejection-sampled range-limited output.
// Optional RNG_REJECT_STATS_EN adds saturating reject/drop counters.
module rng_lfsr_ranged #(
    parameter int             WIDTH          = 16,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(16'hD008),
    parameter int             OUT_W          = 4,
    parameter int             RANGE          = 9,
    parameter int             SHIFTS_PER_NUM = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    rng_lfsr_ranged_if.master out
`ifdef RNG_REJECT_STATS_EN
    ,
    output logic [15:0]      reject_count,
    output logic [15:0]      drop_count
`endif
);

    localparam int CNT_W = (SHIFTS_PER_NUM > 1) ? $clog2(SHIFTS_PER_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SHIFTS_PER_NUM - 1);

    generate
        if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
            $error("rng_lfsr_ranged: WIDTH must be 3..32");
        end
        if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
            $error("rng_lfsr_ranged: OUT_W must be 1..WIDTH");
        end
        if (RANGE < 1 || longint'(RANGE) > (64'd1 << OUT_W)) begin : g_bad_range
            $error("rng_lfsr_ranged: RANGE must be 1..2**OUT_W");
        end
        if (TAPS == '0) begin : g_bad_taps
            $error("rng_lfsr_ranged: TAPS must be nonzero");
        end
        if (SHIFTS_PER_NUM < 1 || SHIFTS_PER_NUM > 256) begin : g_bad_shifts
            $error("rng_lfsr_ranged: SHIFTS_PER_NUM must be 1..256");
        end
    endgenerate

    logic [WIDTH-1:0] lfsr;
    logic [CNT_W-1:0] count;
    logic             valid_q;
    logic [OUT_W-1:0] num_q;

    logic             feedback;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] seed_safe;
    logic [OUT_W-1:0] cand;
    logic             sample;
    logic             fits;
    logic             room;
    logic             accept;
    logic             reject;
    logic             drop;

    assign feedback  = ^(lfsr & TAPS);
    assign shifted   = {lfsr[WIDTH-2:0], feedback};
    // All-zero is a lock-up state; steer any path into it back to 1
    assign lfsr_next = (shifted == '0) ? WIDTH'(1) : shifted;
    assign seed_safe = (seed == '0) ? WIDTH'(1) : seed;

    assign cand   = lfsr[OUT_W-1:0];
    assign sample = !load && enable && (count == LAST);
    assign fits   = 33'(cand) < 33'(RANGE);
    assign room   = !valid_q || out.out_ready;
    assign accept = sample && fits && room;
    assign reject = sample && !fits;
    assign drop   = sample && fits && !room;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr  <= WIDTH'(1);
            count <= '0;
        end else if (load) begin
            lfsr  <= seed_safe;
            count <= '0;
        end else if (enable) begin
            lfsr  <= lfsr_next;
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            num_q   <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            num_q   <= cand;
        end else if (!load && valid_q && out.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out.out_valid = valid_q;
    assign out.num       = num_q;

`ifdef RNG_REJECT_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reject_count <= '0;
            drop_count   <= '0;
        end else if (load) begin
            reject_count <= '0;
            drop_count   <= '0;
        end else begin
            if (reject && reject_count != 16'hFFFF)
                reject_count <= reject_count + 16'd1;
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rng_lfsr_ranged.sv
// Bench for rng_lfsr_ranged: two instances (RANGE 16 and 9) share
// stimulus and are compared against a behavioural model.
module tb_rng_lfsr_ranged;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] seed = 16'h0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rng_lfsr_ranged_if #(.OUT_W(4)) if16 ();
    rng_lfsr_ranged_if #(.OUT_W(4)) if9 ();

`ifdef RNG_REJECT_STATS_EN
    logic [15:0] rc16, dc16, rc9, dc9;
`endif

    rng_lfsr_ranged #(.RANGE(16)) u16 (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .seed(seed), .out(if16.master)
`ifdef RNG_REJECT_STATS_EN
        , .reject_count(rc16), .drop_count(dc16)
`endif
    );

    rng_lfsr_ranged #(.RANGE(9)) u9 (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .seed(seed), .out(if9.master)
`ifdef RNG_REJECT_STATS_EN
        , .reject_count(rc9), .drop_count(dc9)
`endif
    );

    // Reference model: one sample every 16 enabled shifts, rejection
    // against the range, then a one-entry output slot.
    int m_lfsr[2];
    int m_pos[2];
    int m_num[2];
    int m_rej[2];
    int m_drop[2];
    bit m_valid[2];
    int rng[2] = '{16, 9};

    function automatic int lfsr_step(int v);
        int p;
        int n;
        p = $countones(v & 16'hD008) % 2;
        n = ((v << 1) | p) & 16'hFFFF;
        return (n == 0) ? 1 : n;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lfsr[k] = 1; m_pos[k] = 0; m_num[k] = 0;
            m_rej[k] = 0; m_drop[k] = 0; m_valid[k] = 0;
        end
    endfunction

    function automatic void model_step();
        bit rdy;
        bit took;
        bit sampled;
        int cand;
        if (!reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            rdy = (k == 0) ? if16.out_ready : if9.out_ready;
            took = 0;
            sampled = 0;
            cand = 0;
            if (load) begin
                m_lfsr[k] = (seed == 0) ? 1 : int'(seed);
                m_pos[k] = 0;
                m_rej[k] = 0;
                m_drop[k] = 0;
            end else if (enable) begin
                if (m_pos[k] == 15) begin
                    sampled = 1;
                    cand = m_lfsr[k] % 16;
                    m_pos[k] = 0;
                end else begin
                    m_pos[k]++;
                end
                m_lfsr[k] = lfsr_step(m_lfsr[k]);
            end
            if (sampled) begin
                if (cand >= rng[k]) begin
                    if (m_rej[k] < 65535) m_rej[k]++;
                end else if (!m_valid[k] || rdy) begin
                    m_num[k] = cand;
                    m_valid[k] = 1;
                    took = 1;
                end else if (m_drop[k] < 65535) begin
                    m_drop[k]++;
                end
            end
            if (!load && !took && m_valid[k] && rdy)
                m_valid[k] = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        if16.out_ready = 1'b0;
        if9.out_ready = 1'b0;
        model_reset();
        tick();
        tick();
        total++;
        if (if16.out_valid !== 1'b0 || if16.num !== 4'h0) begin
            bad++;
            $display("FAIL reset16: got v=%b n=%h want v=0 n=0",
                     if16.out_valid, if16.num);
        end
        total++;
        if (if9.out_valid !== 1'b0 || if9.num !== 4'h0) begin
            bad++;
            $display("FAIL reset9: got v=%b n=%h want v=0 n=0",
                     if9.out_valid, if9.num);
        end
        total++;
        if (u16.lfsr !== 16'h0001) begin
            bad++;
            $display("FAIL reset_lfsr: got %h want 0001", u16.lfsr);
        end
        reset = 1'b1;
    endtask

    task automatic test_first_sample();
        enable = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e < 16) begin
                total++;
                if (if16.out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL early_valid e=%0d: got %b want 0",
                             e, if16.out_valid);
                end
            end
        end
        total++;
        if (if16.out_valid !== 1'b1 || if16.num !== 4'hD) begin
            bad++;
            $display("FAIL first16: got v=%b n=%h want v=1 n=d",
                     if16.out_valid, if16.num);
        end
        total++;
        if (if9.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reject9: got v=%b want 0", if9.out_valid);
        end
`ifdef RNG_REJECT_STATS_EN
        total++;
        if (rc9 !== 16'd1) begin
            bad++;
            $display("FAIL reject_count: got %0d want 1", rc9);
        end
`endif
        for (int i = 0; i < 100; i++) begin
            tick();
            total++;
            if (if16.out_valid !== 1'b1 || if16.num !== 4'hD) begin
                bad++;
                $display("FAIL hold16 i=%0d: got v=%b n=%h want v=1 n=d",
                         i, if16.out_valid, if16.num);
            end
        end
`ifdef RNG_REJECT_STATS_EN
        total++;
        if (dc16 !== 16'(m_drop[0]) || m_drop[0] != 6) begin
            bad++;
            $display("FAIL drop_count16: got %0d want 6", dc16);
        end
`endif
    endtask

    task automatic test_zero_seed_load();
        load = 1'b1;
        seed = 16'h0000;
        tick();
        load = 1'b0;
        total++;
        if (u16.lfsr !== 16'h0001 || u16.count !== 4'd0) begin
            bad++;
            $display("FAIL zero_seed: got l=%h c=%0d want l=0001 c=0",
                     u16.lfsr, u16.count);
        end
        total++;
        if (if16.out_valid !== 1'b1 || if16.num !== 4'hD) begin
            bad++;
            $display("FAIL load_hold: got v=%b n=%h want v=1 n=d",
                     if16.out_valid, if16.num);
        end
`ifdef RNG_REJECT_STATS_EN
        total++;
        if (rc9 !== 16'd0 || dc16 !== 16'd0) begin
            bad++;
            $display("FAIL load_clr: got r=%0d d=%0d want 0 0", rc9, dc16);
        end
`endif
        if16.out_ready = 1'b1;
        repeat (16) tick();
        total++;
        if (if16.out_valid !== 1'b1 || if16.num !== 4'hD) begin
            bad++;
            $display("FAIL reseq16: got v=%b n=%h want v=1 n=d",
                     if16.out_valid, if16.num);
        end
    endtask

    task automatic test_drop_replace();
        int pre_drop;
        if16.out_ready = 1'b0;
        pre_drop = m_drop[0];
        repeat (16) tick();
        total++;
        if (if16.out_valid !== 1'b1 || if16.num !== 4'hD) begin
            bad++;
            $display("FAIL drop_hold: got v=%b n=%h want v=1 n=d",
                     if16.out_valid, if16.num);
        end
        total++;
        if (m_drop[0] != pre_drop + 1) begin
            bad++;
            $display("FAIL drop_model: got %0d want %0d",
                     m_drop[0], pre_drop + 1);
        end
`ifdef RNG_REJECT_STATS_EN
        total++;
        if (dc16 !== 16'(pre_drop + 1)) begin
            bad++;
            $display("FAIL drop_cnt: got %0d want %0d", dc16, pre_drop + 1);
        end
`endif
        repeat (15) tick();
        if16.out_ready = 1'b1;
        tick();
        if16.out_ready = 1'b0;
        total++;
        if (if16.out_valid !== 1'b1 || if16.num !== 4'(m_num[0])) begin
            bad++;
            $display("FAIL replace: got v=%b n=%h want v=1 n=%h",
                     if16.out_valid, if16.num, m_num[0]);
        end
`ifdef RNG_REJECT_STATS_EN
        total++;
        if (dc16 !== 16'(pre_drop + 1)) begin
            bad++;
            $display("FAIL replace_nodrop: got %0d want %0d",
                     dc16, pre_drop + 1);
        end
`endif
    endtask

    task automatic test_enable_gap();
        if16.out_ready = 1'b1;
        if9.out_ready = 1'b1;
        load = 1'b1;
        seed = 16'h0000;
        tick();
        load = 1'b0;
        for (int e = 1; e <= 26; e++) begin
            enable = (e <= 5 || e > 15);
            tick();
            total++;
            if (e < 26 && if16.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL gap_early e=%0d: got %b want 0",
                         e, if16.out_valid);
            end else if (e == 26 &&
                         (if16.out_valid !== 1'b1 || if16.num !== 4'hD)) begin
                bad++;
                $display("FAIL gap_sample: got v=%b n=%h want v=1 n=d",
                         if16.out_valid, if16.num);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        if16.out_ready = 1'b0;
        tick();
        #3;
        reset = 1'b0;
        #1;
        total++;
        if (if16.out_valid !== 1'b0 || if16.num !== 4'h0 ||
            u16.lfsr !== 16'h0001) begin
            bad++;
            $display("FAIL async_rst: got v=%b n=%h l=%h want 0 0 0001",
                     if16.out_valid, if16.num, u16.lfsr);
        end
        model_reset();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_load_on_sample();
        enable = 1'b1;
        if16.out_ready = 1'b0;
        if9.out_ready = 1'b0;
        repeat (15) tick();
        load = 1'b1;
        seed = 16'h1234;
        tick();
        load = 1'b0;
        total++;
        if (if16.out_valid !== 1'b0 || u16.count !== 4'd0 ||
            u16.lfsr !== 16'h1234) begin
            bad++;
            $display("FAIL load_sample: got v=%b c=%0d l=%h want 0 0 1234",
                     if16.out_valid, u16.count, u16.lfsr);
        end
`ifdef RNG_REJECT_STATS_EN
        total++;
        if (rc9 !== 16'd0) begin
            bad++;
            $display("FAIL load_norej: got %0d want 0", rc9);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            enable = ($urandom_range(0, 9) < 8);
            load = ($urandom_range(0, 99) < 2);
            seed = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            if16.out_ready = $urandom_range(0, 1);
            if9.out_ready = ($urandom_range(0, 3) == 0);
            tick();
            total++;
            if (if16.out_valid !== m_valid[0] ||
                if16.num !== 4'(m_num[0])) begin
                bad++;
                $display("FAIL rnd16 i=%0d: got v=%b n=%h want v=%b n=%h",
                         i, if16.out_valid, if16.num, m_valid[0], m_num[0]);
            end
            total++;
            if (if9.out_valid !== m_valid[1] ||
                if9.num !== 4'(m_num[1])) begin
                bad++;
                $display("FAIL rnd9 i=%0d: got v=%b n=%h want v=%b n=%h",
                         i, if9.out_valid, if9.num, m_valid[1], m_num[1]);
            end
            total++;
            if (if9.out_valid === 1'b1 && if9.num >= 4'd9) begin
                bad++;
                $display("FAIL rnd9_range i=%0d: got %0d want <9",
                         i, if9.num);
            end
`ifdef RNG_REJECT_STATS_EN
            total++;
            if (rc9 !== 16'(m_rej[1]) || dc9 !== 16'(m_drop[1]) ||
                dc16 !== 16'(m_drop[0])) begin
                bad++;
                $display("FAIL rnd_stats i=%0d: got r=%0d d=%0d/%0d want %0d %0d/%0d",
                         i, rc9, dc9, dc16, m_rej[1], m_drop[1], m_drop[0]);
            end
`endif
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_zero_seed_load();
        test_drop_replace();
        test_enable_gap();
        test_async_reset();
        test_load_on_sample();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rng_lfsr_ranged.md
Name: rng_lfsr_ranged

Overview:
- Parametrised Fibonacci LFSR random number generator; the next generation of the game's 16-bit RNG.
- Generalised in register width, tap mask and output width.
- Adds range-limited output via rejection sampling, so game logic receives mole/hole indices 0..RANGE-1 directly.
- Adds a valid/ready output handshake, an enable gate, and zero-seed protection.

Parameters:
- WIDTH, 16: LFSR register width, legal range 3..32.
- TAPS, 16'hD008: feedback tap mask; bit i set means lfsr[i] is XORed into feedback. Default gives taps 16,15,13,4.
- OUT_W, 4: width of the num output; OUT_W <= WIDTH.
- RANGE, 9: number of legal output values, 1..2**OUT_W; num is always < RANGE.
- SHIFTS_PER_NUM, 16: LFSR shifts per candidate sample, legal range 1..256.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  LFSR advances only when high
- load  in  1  synchronous seed load
- seed  in  WIDTH  seed value, sampled when load=1
- out_ready  in  1  consumer accepts num this cycle
- out_valid  out  1  num holds an unconsumed value
- num  out  OUT_W  random value, 0..RANGE-1

Behaviour:
- Reset (reset=0, async): lfsr=1, shift count=0, num=0, out_valid=0. lfsr must never hold 0.
- feedback = XOR-reduce(lfsr & TAPS).
- Shift: lfsr <= {lfsr[WIDTH-2:0], feedback}.
- Precedence per clock edge: load, then enable, then idle.
- Load (load=1):
  - lfsr <= seed, or 1 if seed==0.
  - count <= 0.
  - No sample taken. out_valid and num unchanged.
- Enabled cycle (load=0, enable=1):
  - lfsr shifts.
  - If count == SHIFTS_PER_NUM-1: count <= 0, and candidate = pre-shift lfsr[OUT_W-1:0]. Otherwise count <= count+1.
- enable=0: lfsr and count frozen. Handshake still operates.
- Candidate accept rule: candidate < RANGE, AND (out_valid==0 OR out_ready==1) in the same cycle.
  - If accepted: num <= candidate, out_valid <= 1 on the same edge, so latency from sample cycle is 1 clock.
- Candidate rejected (candidate >= RANGE): discarded; no output change.
- Candidate dropped (output full and out_ready=0): discarded; num held stable.
- Consume: out_valid=1 and out_ready=1 with no accepted candidate -> out_valid <= 0; num keeps its last value.
- Consume and accept in the same cycle: num takes the new candidate, out_valid stays 1.
- While out_valid=1 and out_ready=0, num must not change.
- Reset mid-operation: all state returns to reset values immediately, including any pending valid.
- Illegal parameters (RANGE=0, RANGE>2**OUT_W, OUT_W>WIDTH, TAPS==0) must stop elaboration with an error.
- Count register width: clog2(SHIFTS_PER_NUM), minimum 1 bit. It wraps only through the explicit clear.

Optional Feature:
- Macro: RNG_REJECT_STATS_EN.
- Defined:
  - Adds output reject_count [15:0] and output drop_count [15:0], both saturating at 16'hFFFF.
  - reject_count increments on each rejected candidate; drop_count increments on each dropped candidate.
  - Both cleared by reset and by load.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset, enable=1, defaults except RANGE=16, out_ready=0 -> on the 16th enabled edge the sampled pre-shift lfsr is 16'h888D, num=4'hD, out_valid=1; num stays 4'hD while out_ready=0 for 100 further cycles.
- Reset, enable=1, RANGE=9 -> candidate 13 rejected on the 16th edge, out_valid stays 0; with RNG_REJECT_STATS_EN, reject_count=1.
- load=1 with seed=16'h0000 -> lfsr=16'h0001, count=0. Then 16 enabled cycles with RANGE=16 -> num=4'hD, identical to the post-reset sequence.
- Full output (out_valid=1, out_ready=0) when a valid candidate is sampled -> num unchanged, drop_count increments. Same scenario with out_ready=1 -> num replaced, out_valid stays 1, no drop.
- enable toggled 0 for 10 cycles mid-window -> sample occurs exactly 10 cycles later than with continuous enable, same value.
- Assert reset=0 one cycle after out_valid rises -> out_valid=0 and num=0 immediately, asynchronously. Assert load on the sample cycle -> no sample taken, count=0.
